// File: rtl/pad_bidir_ctrl.sv
// Bidirectional pad controller: arbitrates pad ownership between the core's transmit
// stream and the receive path, with bus turnaround, idle release and an rx synchronizer.
module pad_bidir_ctrl #(
  parameter int TURN_CYCLES  = 2,
  parameter int IDLE_TIMEOUT = 16,
  parameter bit PULL_IN_RX   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic tx_req,
  input  logic tx_bit,
  input  logic tx_last,
  output logic tx_ready,
  input  logic pad_c,
  output logic pad_i,
  output logic pad_oen,
  output logic pad_ren,
  output logic rx_bit,
  output logic rx_valid,
  output logic busy
);

  localparam logic [3:0] TURN_LOAD     = 4'(TURN_CYCLES - 1);
  localparam int         IDLE_LAST_INT = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;
  localparam logic [7:0] IDLE_LAST     = 8'(IDLE_LAST_INT);
  localparam bit         IDLE_EN       = (IDLE_TIMEOUT != 0);

  typedef enum logic [2:0] {
    ST_RX,
    ST_TURN_TX,
    ST_TX,
    ST_DRAIN,
    ST_TURN_RX
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] turn_cnt;
  logic [7:0] idle_cnt;
  logic       ren_q;
  logic [1:0] sync_q;
  logic       rx_hist;
  logic       transfer;

  assign transfer = tx_req & tx_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_RX:      if (tx_req) state_next = ST_TURN_TX;
      ST_TURN_TX: begin
        if (!tx_req)                state_next = ST_RX;
        else if (turn_cnt == 4'd0)  state_next = ST_TX;
      end
      ST_TX: begin
        if (transfer && tx_last)
          state_next = ST_DRAIN;
        else if (!transfer && IDLE_EN && idle_cnt == IDLE_LAST)
          state_next = ST_DRAIN;
      end
      ST_DRAIN:   state_next = ST_TURN_RX;
      ST_TURN_RX: if (turn_cnt == 4'd0) state_next = ST_RX;
      default:    state_next = ST_RX;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RX;
      turn_cnt <= '0;
      idle_cnt <= '0;
      pad_i    <= 1'b0;
      pad_oen  <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      ren_q    <= ~PULL_IN_RX;
      sync_q   <= '0;
      rx_hist  <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      state <= state_next;

      if ((state == ST_RX && state_next == ST_TURN_TX) || state == ST_DRAIN)
        turn_cnt <= TURN_LOAD;
      else if (turn_cnt != 4'd0 && (state == ST_TURN_TX || state == ST_TURN_RX))
        turn_cnt <= turn_cnt - 4'd1;

      // Saturate so a disabled timeout never wraps back into a stale compare value.
      if (state != ST_TX || transfer)
        idle_cnt <= '0;
      else if (idle_cnt != 8'hFF)
        idle_cnt <= idle_cnt + 8'd1;

      if (transfer) pad_i <= tx_bit;

      pad_oen  <= !(state_next == ST_TX || state_next == ST_DRAIN);
      tx_ready <= (state_next == ST_TX);
      busy     <= (state_next != ST_RX);
      ren_q    <= !(state_next == ST_RX && PULL_IN_RX);

      sync_q   <= {sync_q[0], pad_c};
      rx_hist  <= (state == ST_RX);
      rx_valid <= rx_hist && (state == ST_RX);
    end
  end

  // ren_q already holds the RX value during reset; the reset term keeps the pull off
  // while reset is asserted and lets it engage in the first cycle after release.
  assign pad_ren = ren_q | reset;
  assign rx_bit  = sync_q[1];

endmodule

// File: tb/tb_pad_bidir_ctrl.sv
// Bench for pad_bidir_ctrl: two configurations driven with directed and random stimulus,
// each compared every cycle against a phase/remaining-cycles reference model.
module tb_pad_bidir_ctrl;

  logic clk = 1'b0;
  logic rst, req, tbit, tlast, padc;

  logic u0_tx_ready, u0_pad_i, u0_pad_oen, u0_pad_ren, u0_rx_bit, u0_rx_valid, u0_busy;
  logic u1_tx_ready, u1_pad_i, u1_pad_oen, u1_pad_ren, u1_rx_bit, u1_rx_valid, u1_busy;

  always #5 clk = ~clk;

  pad_bidir_ctrl u0 (
    .clk(clk), .reset(rst), .tx_req(req), .tx_bit(tbit), .tx_last(tlast),
    .tx_ready(u0_tx_ready), .pad_c(padc), .pad_i(u0_pad_i), .pad_oen(u0_pad_oen),
    .pad_ren(u0_pad_ren), .rx_bit(u0_rx_bit), .rx_valid(u0_rx_valid), .busy(u0_busy)
  );

  pad_bidir_ctrl #(.TURN_CYCLES(1), .IDLE_TIMEOUT(3), .PULL_IN_RX(1'b0)) u1 (
    .clk(clk), .reset(rst), .tx_req(req), .tx_bit(tbit), .tx_last(tlast),
    .tx_ready(u1_tx_ready), .pad_c(padc), .pad_i(u1_pad_i), .pad_oen(u1_pad_oen),
    .pad_ren(u1_pad_ren), .rx_bit(u1_rx_bit), .rx_valid(u1_rx_valid), .busy(u1_busy)
  );

  // Reference model: phase plus cycles remaining in it, plus short histories.
  localparam int P_RX = 0, P_TTX = 1, P_TX = 2, P_DR = 3, P_TRX = 4;

  typedef struct {
    int       ph;
    int       left;
    int       idle;
    bit       pi;
    bit [1:0] pc;
    bit [1:0] rxh;
  } mdl_t;

  typedef struct {
    int turn;
    int idle_to;
    bit pull;
  } cfg_t;

  cfg_t c0 = '{turn: 2, idle_to: 16, pull: 1'b1};
  cfg_t c1 = '{turn: 1, idle_to: 3,  pull: 1'b0};
  mdl_t m0, m1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [6:0] obs0, obs1;

  // Output vector layout: {tx_ready, pad_i, pad_oen, pad_ren, rx_bit, rx_valid, busy}
  function automatic logic [6:0] m_out(mdl_t m, cfg_t c, bit r);
    return {m.ph == P_TX, m.pi, !(m.ph == P_TX || m.ph == P_DR),
            r || !(m.ph == P_RX && c.pull), m.pc[1], m.rxh[0] && m.rxh[1], m.ph != P_RX};
  endfunction

  function automatic mdl_t m_step(mdl_t m, cfg_t c, bit r, bit rq, bit b, bit last, bit pc);
    mdl_t n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.pc  = {m.pc[0], pc};
    n.rxh = {m.rxh[0], m.ph == P_RX};
    case (m.ph)
      P_RX:  if (rq) begin n.ph = P_TTX; n.left = c.turn; end
      P_TTX: begin
        if (!rq) n.ph = P_RX;
        else begin
          n.left = m.left - 1;
          if (n.left == 0) begin n.ph = P_TX; n.idle = 0; end
        end
      end
      P_TX: begin
        if (rq) begin
          n.pi = b;
          n.idle = 0;
          if (last) n.ph = P_DR;
        end else begin
          n.idle = m.idle + 1;
          if (c.idle_to != 0 && n.idle == c.idle_to) n.ph = P_DR;
        end
      end
      P_DR:  begin n.ph = P_TRX; n.left = c.turn; end
      default: begin
        n.left = m.left - 1;
        if (n.left == 0) n.ph = P_RX;
      end
    endcase
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: sample mid-cycle, compare both DUTs to the model, advance.
  task automatic tick();
    @(negedge clk);
    obs0 = {u0_tx_ready, u0_pad_i, u0_pad_oen, u0_pad_ren, u0_rx_bit, u0_rx_valid, u0_busy};
    obs1 = {u1_tx_ready, u1_pad_i, u1_pad_oen, u1_pad_ren, u1_rx_bit, u1_rx_valid, u1_busy};
    check("u0_model", obs0, m_out(m0, c0, rst));
    check("u1_model", obs1, m_out(m1, c1, rst));
    m0 = m_step(m0, c0, rst, req, tbit, tlast, padc);
    m1 = m_step(m1, c1, rst, req, tbit, tlast, padc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  bit b_oen [12] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  bit b_rdy [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  bit b_busy[12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  bit b_pi  [12] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
  bit b_rxv [12] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  bit a_busy[5]  = '{0, 1, 1, 0, 0};
  logic [6:0] idle_exp[5] = '{7'b1100001, 7'b0100001, 7'b0110001, 7'b0110001, 7'b0110000};

  initial begin
    int mode;
    rst = 1'b1; req = 1'b0; tbit = 1'b0; tlast = 1'b0; padc = 1'b0;
    @(posedge clk);
    #1;
    m0 = '{default: 0};
    m1 = '{default: 0};

    // Reset values.
    tick();
    tick();
    check("reset_u0", obs0, 7'b0011000);
    check("reset_u1", obs1, 7'b0011000);
    rst = 1'b0;
    repeat (4) tick();

    // Three-bit burst, last bit tagged.
    for (int i = 0; i < 12; i++) begin
      req   = (i <= 5);
      tbit  = (i <= 5) && (i != 4);
      tlast = (i == 5);
      tick();
      check("burst", obs0 & 7'b1110011,
            {b_rdy[i], b_pi[i], b_oen[i], 1'b0, 1'b0, b_rxv[i], b_busy[i]});
    end
    req = 1'b0; tbit = 1'b0; tlast = 1'b0;
    repeat (4) tick();

    // Request withdrawn during turnaround.
    for (int i = 0; i < 5; i++) begin
      req = (i <= 1);
      tick();
      check("abort", {obs0[4], obs0[0]}, {1'b1, a_busy[i]});
    end
    repeat (6) tick();

    // One transfer then silence: idle release.
    for (int i = 0; i < 24; i++) begin
      req  = (i <= 3);
      tbit = 1'b1;
      tick();
      if (i >= 19) check("idle_release", obs0 & 7'b1110001, idle_exp[i - 19]);
    end
    req = 1'b0;
    repeat (4) tick();

    // Receive synchronizer latency.
    padc = 1'b1;
    tick();
    tick();
    check("rx_sync_early", obs0[2:1], 2'b01);
    tick();
    check("rx_sync", obs0[2:1], 2'b11);
    padc = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a transmit.
    req = 1'b1; tbit = 1'b1; tlast = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("pre_reset_tx", obs0 & 7'b0110000, 7'b0100000);
    rst = 1'b0;
    tick();
    check("reset_release", obs0 & 7'b1111001, 7'b0010000);
    tick();
    check("reset_reenter", obs0 & 7'b1010001, 7'b0010001);
    req = 1'b0;
    repeat (8) tick();

    // Random traffic in phases of differing request density.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mode = int'($urandom_range(0, 2));
      rst   = ($urandom_range(0, 299) == 0);
      case (mode)
        0:       req = ($urandom_range(0, 9) != 0);
        1:       req = ($urandom_range(0, 9) < 3);
        default: req = ($urandom_range(0, 49) == 0);
      endcase
      tbit  = 1'($urandom_range(0, 1));
      tlast = ($urandom_range(0, 5) == 0);
      padc  = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_bidir_ctrl.md
PAD_BIDIR_CTRL -- requirements
Module: pad_bidir_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 2, bus-turnaround cycles with pad undriven; legal range 1..15.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 16, consecutive no-transfer cycles in TX before forced release; 0 disables; legal range 0..255.
REQ-003 SHALL have parameter PULL_IN_RX, default 1; 1 enables the pad pull (pad_ren=0) while in RX.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock (all state on rising edge).
REQ-005 SHALL have reset  input  1  synchronous active-high reset.
REQ-006 SHALL have tx_req  input  1  core requests ownership of pad / offers tx_bit.
REQ-007 SHALL have tx_bit  input  1  data bit to drive.
REQ-008 SHALL have tx_last  input  1  marks final bit of a burst.
REQ-009 SHALL have tx_ready  output  1  bit accepted this cycle when tx_req&tx_ready.
REQ-010 SHALL have pad_c  input  1  pad receive path (asynchronous to clk).
REQ-011 SHALL have pad_i  output  1  pad drive data.
REQ-012 SHALL have pad_oen  output  1  pad output enable, active low.
REQ-013 SHALL have pad_ren  output  1  pad pull enable, active low.
REQ-014 SHALL have rx_bit  output  1  synchronized pad value.
REQ-015 SHALL have rx_valid  output  1  rx_bit sampled while pad undriven by this block.
REQ-016 SHALL have busy  output  1  state != RX.

Function
REQ-017 SHALL implement FSM states RX, TURN_TX, TX, DRAIN, TURN_RX; pad_oen, pad_ren, tx_ready, busy are Moore functions of the registered state.
REQ-018 pad_oen SHALL be 0 only in TX and DRAIN; 1 otherwise.
REQ-019 pad_ren SHALL be 0 only in RX with PULL_IN_RX=1; 1 otherwise.
REQ-020 RX -> TURN_TX when tx_req=1; the 4-bit turn counter loads TURN_CYCLES-1.
REQ-021 TURN_TX: counter decrements each cycle; on 0 -> TX; total TURN_CYCLES cycles in TURN_TX.
REQ-022 tx_req=0 in any TURN_TX cycle SHALL abort: next state RX, no transfer occurs.
REQ-023 tx_ready SHALL be 1 exactly in TX; a transfer is tx_req&tx_ready.
REQ-024 pad_i SHALL be a register loaded with tx_bit on each transfer; the bit transferred in cycle k is on pad_i from cycle k+1; pad_i holds between transfers.
REQ-025 A transfer with tx_last=1 SHALL move TX -> DRAIN; DRAIN lasts exactly 1 cycle (last bit still driven), then TURN_RX.
REQ-026 In TX, an 8-bit idle counter SHALL count consecutive non-transfer cycles, cleared on transfer; reaching IDLE_TIMEOUT (when nonzero) SHALL force TX -> DRAIN.
REQ-027 TURN_RX SHALL last exactly TURN_CYCLES cycles, then RX; tx_req is ignored during DRAIN and TURN_RX.
REQ-028 pad_c SHALL pass through a 2-flop synchronizer; rx_bit in cycle t equals pad_c sampled in cycle t-2.
REQ-029 rx_valid in cycle t SHALL be 1 iff state was RX in cycles t-1 and t-2.
REQ-030 With tx_req held high after a burst, the FSM SHALL pass RX for exactly one cycle before re-entering TURN_TX (no RX bypass).

Reset
REQ-031 During reset: state RX, pad_oen=1, pad_i=0, pad_ren=1, tx_ready=0, busy=0, rx_valid=0, rx_bit=0, synchronizer, counters and rx_valid history cleared.
REQ-032 Reset asserted in any state SHALL take effect next edge, releasing the pad immediately (pad_oen=1 the cycle after reset samples high), with no DRAIN or turnaround.
REQ-033 First cycle after reset deasserts: state RX, pad_ren=PULL_IN_RX?0:1; rx_valid first 1 two cycles later.

Verification
REQ-034 Defaults, tx_req rises cycle 10, held, tx_bit=1,0,1 with tx_last on 3rd -> TURN_TX 11-12, TX 13-15 with transfers, pad_i=1,0,1 cycles 14-16, DRAIN 16, TURN_RX 17-18, RX 19; pad_oen=0 cycles 13-16 only.
REQ-035 tx_req pulses cycles 10-11 only -> TURN_TX cycles 11-12 with abort seen in cycle 12 -> RX cycle 13; pad_oen stays 1 throughout.
REQ-036 Enter TX, one transfer, then tx_req=0 -> after 16 idle cycles DRAIN, then TURN_RX 2 cycles, RX; pad_i holds transferred bit until release.
REQ-037 RX idle, pad_c toggles 0->1 at cycle 20 -> rx_bit=1 at cycle 22, rx_valid=1; during/just after a burst rx_valid=0 until 2 cycles into RX.
REQ-038 Reset asserted mid-TX with pad_i=1 -> next cycle pad_oen=1, pad_i=0, busy=0, tx_ready=0; tx_req held high then -> TURN_TX one cycle after reset deasserts.
REQ-039 TURN_CYCLES=1, PULL_IN_RX=0 -> single-cycle turnarounds; pad_ren=1 in all states.
